// File: rtl/data_mem_unit_pkg.sv
// Shared types, size/state encodings and lane helpers for the data-memory stage.
package data_mem_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Pull the addressed lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  lane_extract = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  lane_extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: lane_extract = word;
    endcase
  endfunction

  // Misaligned, reserved size, or word index beyond the array (full-width compare).
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr,
                                      input int unsigned depth);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = addr[0];
      SIZE_W:  mis = |addr[1:0];
      default: mis = 1'b1;
    endcase
    return mis | (addr[31:2] >= 30'(depth));
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus between the core and the data-memory stage.
interface data_mem_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_unit_mem_lane_align.sv
// Byte-lane steering: load extract/extend, store byte enables and replicated write data.
module mem_lane_align
  import data_mem_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_c,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c
);

  always_comb begin
    rdata_c = lane_extract(size, uns, off, rword);
    be_c    = 4'b0000;
    wdata_c = wdata;
    case (size)
      SIZE_B: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be_c    = 4'b0011 << off;
        wdata_c = {2{wdata[15:0]}};
      end
      SIZE_W:  be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: byte/half/word loads and stores with configurable latency
// and valid/ready handshake; misaligned and out-of-range accesses are flagged.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned INIT_IDX = 1
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_unit_if.slave   bus,
  output logic             busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  mem_req_t         req, req_d;
  logic             ready_d, valid_d, err_d, busy_d, mem_we, acc_err;
  logic [31:0]      rdata_d, rword, pat, al_rdata, al_wdata;
  logic [3:0]       al_be;
  logic [IDX_W-1:0] idx;

  // Words are stored XOR-ed with their power-up image, so an all-zero array reads back initialised.
  logic [31:0] mem [DEPTH];

  assign idx     = req_d.addr[IDX_W+1:2];
  assign pat     = (INIT_IDX != 0) ? 32'(idx) : 32'h0;
  assign rword   = mem[idx] ^ pat;
  assign acc_err = access_err(req_d.size, req_d.addr, DEPTH);

  mem_lane_align u_align (
    .size    (req_d.size),
    .uns     (req_d.uns),
    .off     (req_d.addr[1:0]),
    .rword   (rword),
    .wdata   (req_d.wdata),
    .rdata_c (al_rdata),
    .be_c    (al_be),
    .wdata_c (al_wdata)
  );

  // Next state and next registered outputs; req_d equals req outside IDLE.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = req;
    ready_d = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
    case (state)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (bus.req_valid && bus.req_ready) begin
          req_d   = '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned,
                      addr: bus.req_addr, wdata: bus.req_wdata};
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
          ready_d = 1'b0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        valid_d = 1'b1;
        err_d   = acc_err;
        rdata_d = (acc_err || req.we) ? 32'h0 : al_rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    mem_we = (state_d == ST_RESP) && (state != ST_RESP) && req_d.we && !acc_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      req            <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'h0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      req            <= req_d;
      bus.req_ready  <= ready_d;
      bus.resp_valid <= valid_d;
      bus.resp_err   <= err_d;
      bus.resp_rdata <= rdata_d;
      busy           <= busy_d;
    end
  end

  // Store commit on the edge entering RESP; reset suppresses it.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (al_be[b]) mem[idx][8*b +: 8] <= al_wdata[8*b +: 8] ^ pat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench: directed vector table, latency/reset sequences and a random
// phase against a byte-array reference model, on LATENCY=1 and LATENCY=4 instances.
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned MEMB  = DEPTH * 4;
  localparam int          N_VEC = 16;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk, rst1, rst4, v1, v4, busy1, busy4;
  logic        q_we, q_uns;
  logic [1:0]  q_size;
  logic [31:0] q_addr, q_wdata;
  int          errors, checks, acc4;
  logic [7:0]  mb [2][MEMB];
  vec_t        tbl [N_VEC];

  data_mem_unit_if b1 ();
  data_mem_unit_if b4 ();

  assign b1.req_valid = v1;     assign b4.req_valid = v4;
  assign b1.req_we = q_we;      assign b4.req_we = q_we;
  assign b1.req_size = q_size;  assign b4.req_size = q_size;
  assign b1.req_unsigned = q_uns; assign b4.req_unsigned = q_uns;
  assign b1.req_addr = q_addr;  assign b4.req_addr = q_addr;
  assign b1.req_wdata = q_wdata; assign b4.req_wdata = q_wdata;

  data_mem_unit #(.DEPTH(DEPTH), .LATENCY(1), .INIT_IDX(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1.slave), .busy(busy1));
  data_mem_unit #(.DEPTH(DEPTH), .LATENCY(4), .INIT_IDX(1)) dut4 (
    .clk(clk), .rst(rst4), .bus(b4.slave), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rst4 && v4 && b4.req_ready) acc4 <= acc4 + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Little-endian byte-array model of the memory; stores update it, loads assemble and extend.
  function automatic void model(input int s, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int n;
    longint unsigned v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (addr % n != 0) || (addr >= MEMB);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int b = 0; b < n; b++) mb[s][addr + b] = 8'(wdata >> (8 * b));
    end else begin
      v = 0;
      for (int b = 0; b < n; b++) v += longint'(mb[s][addr + b]) << (8 * b);
      if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      rdata = 32'(v);
    end
  endfunction

  task automatic xact(input int s, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat, output logic ok);
    int n;
    ok = 1'b0; rdata = 32'h0; err = 1'b0; lat = 0;
    @(negedge clk);
    q_we = we; q_size = size; q_uns = uns; q_addr = addr; q_wdata = wdata;
    if (s == 1) v4 = 1'b1; else v1 = 1'b1;
    n = 0;
    while (((s == 1) ? b4.req_ready : b1.req_ready) !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    if (n < 40) begin
      @(posedge clk); #1;
      v1 = 1'b0; v4 = 1'b0;
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (((s == 1) ? b4.resp_valid : b1.resp_valid) !== 1'b1 && n < 40);
      ok    = (s == 1) ? b4.resp_valid : b1.resp_valid;
      lat   = n;
      rdata = (s == 1) ? b4.resp_rdata : b1.resp_rdata;
      err   = (s == 1) ? b4.resp_err : b1.resp_err;
    end
    v1 = 1'b0; v4 = 1'b0;
  endtask

  initial begin
    logic [31:0] ar, er;
    logic        ae, ee, ok, seen;
    int          lat, a0, n;

    errors = 0; checks = 0; acc4 = 0;
    rst1 = 1'b0; rst4 = 1'b0; v1 = 1'b0; v4 = 1'b0;
    q_we = 1'b0; q_size = SIZE_W; q_uns = 1'b0; q_addr = 32'h0; q_wdata = 32'h0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < int'(DEPTH); w++)
        for (int j = 0; j < 4; j++) mb[s][4 * w + j] = 8'(w >> (8 * j));

    tbl[0]  = '{1'b0, SIZE_W, 1'b0, 32'h14, 32'h0, 32'h5, 1'b0};
    tbl[1]  = '{1'b1, SIZE_W, 1'b0, 32'h20, 32'h80FF7F01, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, SIZE_B, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0};
    tbl[3]  = '{1'b0, SIZE_B, 1'b1, 32'h23, 32'h0, 32'h80, 1'b0};
    tbl[4]  = '{1'b0, SIZE_B, 1'b0, 32'h20, 32'h0, 32'h1, 1'b0};
    tbl[5]  = '{1'b1, SIZE_H, 1'b0, 32'h22, 32'hBEEF, 32'h0, 1'b0};
    tbl[6]  = '{1'b0, SIZE_W, 1'b0, 32'h20, 32'h0, 32'hBEEF7F01, 1'b0};
    tbl[7]  = '{1'b0, SIZE_H, 1'b0, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0};
    tbl[8]  = '{1'b0, SIZE_H, 1'b1, 32'h22, 32'h0, 32'hBEEF, 1'b0};
    tbl[9]  = '{1'b0, SIZE_W, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{1'b1, SIZE_H, 1'b0, 32'h33, 32'h1234, 32'h0, 1'b1};
    tbl[11] = '{1'b0, SIZE_W, 1'b0, 32'h30, 32'h0, 32'hC, 1'b0};
    tbl[12] = '{1'b0, SIZE_W, 1'b0, 32'(MEMB), 32'h0, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b0, SIZE_W, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1};
    tbl[15] = '{1'b0, SIZE_B, 1'b0, 32'h1FC, 32'h0, 32'h7F, 1'b0};

    // Reset for two cycles, then check idle outputs
    repeat (2) @(posedge clk);
    #1; rst1 = 1'b1; rst4 = 1'b1;
    chk("rst_ready", 32'(b1.req_ready), 32'd1);
    chk("rst_valid", 32'(b1.resp_valid), 32'd0);
    chk("rst_err", 32'(b1.resp_err), 32'd0);
    chk("rst_rdata", b1.resp_rdata, 32'h0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ready4", 32'(b4.req_ready), 32'd1);

    for (int i = 0; i < N_VEC; i++) begin
      xact(0, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, ar, ae, lat, ok);
      model(0, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, er, ee);
      chk($sformatf("vec%0d_resp", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_rdata", i), ar, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(ae), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
    end

    // LATENCY=4: timing of ready/valid/busy with req_valid held across two requests
    @(negedge clk);
    chk("t5_ready_idle", 32'(b4.req_ready), 32'd1);
    q_we = 1'b0; q_size = SIZE_W; q_uns = 1'b0; q_addr = 32'h8; v4 = 1'b1; a0 = acc4;
    @(posedge clk); #1;
    q_addr = 32'h30;
    chk("t5_accept1", 32'(acc4 - a0), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk($sformatf("t5_ready_k%0d", k), 32'(b4.req_ready), 32'(k == 5));
      chk($sformatf("t5_valid_k%0d", k), 32'(b4.resp_valid), 32'(k == 4));
      chk($sformatf("t5_busy_k%0d", k), 32'(busy4), 32'(k < 4));
      if (k == 4) chk("t5_rdata1", b4.resp_rdata, 32'h2);
    end
    @(posedge clk); #1;
    v4 = 1'b0;
    chk("t5_accept2", 32'(acc4 - a0), 32'd2);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (b4.resp_valid !== 1'b1 && n < 20);
    chk("t5_lat2", 32'(n), 32'd4);
    chk("t5_rdata2", b4.resp_rdata, 32'hC);

    // Reset in the second cycle of an in-flight store drops it silently
    n = 0;
    @(negedge clk);
    while (b4.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    q_we = 1'b1; q_size = SIZE_W; q_addr = 32'h40; q_wdata = 32'hDEAD; v4 = 1'b1;
    @(posedge clk); #1; v4 = 1'b0;
    @(posedge clk); #1; rst4 = 1'b0;
    @(posedge clk); #1; rst4 = 1'b1;
    chk("t6_busy", 32'(busy4), 32'd0);
    chk("t6_ready", 32'(b4.req_ready), 32'd1);
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen = seen | b4.resp_valid; end
    chk("t6_noresp", 32'(seen), 32'd0);
    xact(1, 1'b0, SIZE_W, 1'b0, 32'h40, 32'h0, ar, ae, lat, ok);
    model(1, 1'b0, SIZE_W, 1'b0, 32'h40, 32'h0, er, ee);
    chk("t6_resp", 32'(ok), 32'd1);
    chk("t6_rdata", ar, 32'h10);

    // Random traffic on both instances against the byte-array model
    for (int i = 0; i < 240; i++) begin
      int          s, m;
      logic        we, uns;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      s   = (i % 4 == 3) ? 1 : 0;
      m   = int'($urandom_range(0, 9));
      sz  = (m < 3) ? SIZE_B : (m < 6) ? SIZE_H : (m < 9) ? SIZE_W : 2'd3;
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom();
      m   = int'($urandom_range(0, 9));
      if (m < 8)       a = $urandom_range(0, 127);
      else if (m == 8) a = MEMB - 8 + $urandom_range(0, 15);
      else             a = $urandom();
      model(s, we, sz, uns, a, wd, er, ee);
      xact(s, we, sz, uns, a, wd, ar, ae, lat, ok);
      chk($sformatf("rnd%0d_resp", i), 32'(ok), 32'd1);
      chk($sformatf("rnd%0d_rdata a=%08h", i, a), ar, er);
      chk($sformatf("rnd%0d_err a=%08h", i, a), 32'(ae), 32'(ee));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), (s == 1) ? 32'd4 : 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
